// File: rtl/jedro_1_test_monitor.sv
// Test-run monitor for a core under test. It starts on start_i and stops on illegal_instr_i or on timeout.
// After a drain window it checks a shadowed register-file value against the expected value.
module jedro_1_test_monitor #(
   parameter int DATA_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int CHECK_REG       = 31,
   parameter int EXPECTED_VALUE  = 1,
   parameter int TIMEOUT_CYCLES  = 32,
   parameter int DRAIN_CYCLES    = 3,
   parameter int TIMEOUT_IS_FAIL = 0,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      start_i,
   input  logic                      illegal_instr_i,
   input  logic                      rf_we_i,
   input  logic [REG_ADDR_WIDTH-1:0] rf_waddr_i,
   input  logic [DATA_WIDTH-1:0]     rf_wdata_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      pass_o,
   output logic                      fail_o,
   output logic                      timeout_o,
   output logic [DATA_WIDTH-1:0]     result_o,
   output logic [CNT_WIDTH-1:0]      cycles_o
);

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, CHECK, DONE} state_t;

   localparam int DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam logic [DRW-1:0] DRAIN_LAST =
      DRW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [REG_ADDR_WIDTH-1:0] CHECK_ADDR = REG_ADDR_WIDTH'(CHECK_REG);
   localparam logic [DATA_WIDTH-1:0] EXPECTED = DATA_WIDTH'(EXPECTED_VALUE);

   state_t                state_q, state_d;
   logic [DRW-1:0]        drain_q;
   logic [CNT_WIDTH-1:0]  cycles_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  timeout_q, pass_q, fail_q;
   logic                  start_ok, timeout_hit, stop, capture, verdict;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // A saturated counter also forces the stop, so a timeout beyond the counter range cannot hang RUN
   assign timeout_hit = (cycles_q == TIMEOUT_LAST) || (&cycles_q);
   assign start_ok    = start_i && ((state_q == IDLE) || (state_q == DONE));
   assign stop        = (state_q == RUN) && (illegal_instr_i || timeout_hit);
   assign capture     = ((state_q == RUN) || (state_q == DRAIN)) && rf_we_i &&
                        (rf_waddr_i == CHECK_ADDR);
   assign verdict     = (result_q == EXPECTED) && !((TIMEOUT_IS_FAIL != 0) && timeout_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = RUN;
         RUN:     if (stop) state_d = (DRAIN_CYCLES == 0) ? CHECK : DRAIN;
         DRAIN:   if (drain_q == DRAIN_LAST) state_d = CHECK;
         CHECK:   state_d = DONE;
         DONE:    if (start_i) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         drain_q   <= '0;
         cycles_q  <= '0;
         result_q  <= '0;
         timeout_q <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= (state_q == DRAIN) ? drain_q + DRW'(1) : '0;
         if (start_ok) begin
            cycles_q  <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
         end else begin
            if (state_q == RUN) begin
               cycles_q <= sat_inc(cycles_q);
               // illegal_instr_i wins over a timeout in the same cycle
               if (stop) timeout_q <= !illegal_instr_i;
            end
            if (capture) result_q <= rf_wdata_i;
            if (state_q == CHECK) begin
               pass_q <= verdict;
               fail_q <= !verdict;
            end
         end
      end
   end

   assign busy_o    = (state_q == RUN) || (state_q == DRAIN) || (state_q == CHECK);
   assign done_o    = (state_q == DONE);
   assign pass_o    = pass_q;
   assign fail_o    = fail_q;
   assign timeout_o = timeout_q;
   assign result_o  = result_q;
   assign cycles_o  = cycles_q;

endmodule

// File: tb/tb_jedro_1_test_monitor.sv
// Scoreboard bench for jedro_1_test_monitor. Three parameterisations share one stimulus stream.
// Expected verdicts are queued per instance and checked when each done_o rises.
module tb_jedro_1_test_monitor;

   logic        clk = 1'b0;
   logic        rstn, start, ill, we;
   logic [4:0]  waddr;
   logic [31:0] wdata;

   logic        busy [3];
   logic        done [3];
   logic        pass [3];
   logic        fail [3];
   logic        tmo  [3];
   logic [31:0] res  [3];
   logic [15:0] cyo  [3];
   logic        done_d [3];

   typedef struct packed {
      logic        p;
      logic        t;
      logic [31:0] r;
      logic [31:0] c;
      logic [31:0] l;
   } exp_t;

   exp_t sbq [3][$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_cyc = 0;

   // instance 0: defaults, 1: timeout counts as fail, 2: no drain window
   jedro_1_test_monitor u_a (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .illegal_instr_i(ill),
      .rf_we_i(we), .rf_waddr_i(waddr), .rf_wdata_i(wdata),
      .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .fail_o(fail[0]),
      .timeout_o(tmo[0]), .result_o(res[0]), .cycles_o(cyo[0]));

   jedro_1_test_monitor #(.TIMEOUT_IS_FAIL(1)) u_b (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .illegal_instr_i(ill),
      .rf_we_i(we), .rf_waddr_i(waddr), .rf_wdata_i(wdata),
      .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .fail_o(fail[1]),
      .timeout_o(tmo[1]), .result_o(res[1]), .cycles_o(cyo[1]));

   jedro_1_test_monitor #(.DRAIN_CYCLES(0)) u_c (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .illegal_instr_i(ill),
      .rf_we_i(we), .rf_waddr_i(waddr), .rf_wdata_i(wdata),
      .busy_o(busy[2]), .done_o(done[2]), .pass_o(pass[2]), .fail_o(fail[2]),
      .timeout_o(tmo[2]), .result_o(res[2]), .cycles_o(cyo[2]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int i, input logic p, input logic t, input logic [31:0] r,
                       input int c, input int l);
      exp_t e;
      e.p = p; e.t = t; e.r = r; e.c = c; e.l = l;
      sbq[i].push_back(e);
   endtask

   // monitor: compare every rising done_o against the head of that instance's queue
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (done[i] && !done_d[i]) begin
            if (sbq[i].size() == 0) begin
               chk($sformatf("unexpected_done[%0d] queue_size_plus1", i), sbq[i].size() + 1, 0);
            end else begin
               mon_e = sbq[i].pop_front();
               chk($sformatf("pass[%0d]", i), pass[i], mon_e.p);
               chk($sformatf("fail[%0d]", i), fail[i], !mon_e.p);
               chk($sformatf("timeout[%0d]", i), tmo[i], mon_e.t);
               chk($sformatf("result[%0d]", i), res[i], mon_e.r);
               chk($sformatf("cycles[%0d]", i), cyo[i], mon_e.c);
               chk($sformatf("latency[%0d]", i), cyc - start_cyc, mon_e.l);
               chk($sformatf("busy_in_done[%0d]", i), busy[i], 0);
            end
         end
         done_d[i] <= done[i];
      end
   end

   // one run: start pulse, then n RUN-relative cycles of stimulus (cycle index 0 = unused)
   task automatic run(input int n, input int w1c, input logic [4:0] w1a, input logic [31:0] w1d,
                      input int w2c, input logic [4:0] w2a, input logic [31:0] w2d,
                      input int ill_c, input int st_c);
      @(negedge clk);
      start = 1'b1;
      start_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", busy[0], 1);
      chk("start_done_clr", done[0], 0);
      chk("start_pass_clr", pass[0], 0);
      chk("start_fail_clr", fail[0], 0);
      chk("start_tmo_clr", tmo[0], 0);
      chk("start_res_clr", res[0], 0);
      chk("start_cyc_clr", cyo[0], 0);
      for (int k = 1; k <= n; k++) begin
         we    = (k == w1c) || (k == w2c);
         waddr = (k == w1c) ? w1a : w2a;
         wdata = (k == w1c) ? w1d : w2d;
         ill   = (k == ill_c);
         start = (k == st_c);
         @(negedge clk);
      end
      we = 1'b0; ill = 1'b0; start = 1'b0; waddr = '0; wdata = '0;
   endtask

   task automatic wait_done();
      for (int n = 0; n < 200 && !done[0]; n++) @(negedge clk);
      chk("done_reached", done[0], 1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, expected finish");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; start = 1'b0; ill = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      for (int i = 0; i < 3; i++) done_d[i] = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_busy[%0d]", i), busy[i], 0);
         chk($sformatf("rst_done[%0d]", i), done[i], 0);
         chk($sformatf("rst_pass[%0d]", i), pass[i], 0);
         chk($sformatf("rst_fail[%0d]", i), fail[i], 0);
         chk($sformatf("rst_res[%0d]", i), res[i], 0);
         chk($sformatf("rst_cyc[%0d]", i), cyo[i], 0);
      end
      rstn = 1'b1;
      @(negedge clk);

      // x31=1 at cycle 4, illegal at cycle 6
      push(0, 1, 0, 1, 6, 10); push(1, 1, 0, 1, 6, 10); push(2, 1, 0, 1, 6, 7);
      run(6, 4, 5'd31, 32'd1, 0, 5'd0, 32'd0, 6, 0);
      wait_done();

      // wrong value -> fail; restarts from DONE
      push(0, 0, 0, 5, 3, 7); push(1, 0, 0, 5, 3, 7); push(2, 0, 0, 5, 3, 4);
      run(3, 2, 5'd31, 32'd5, 0, 5'd0, 32'd0, 3, 0);
      wait_done();

      // no illegal: timeout after 32 RUN cycles
      push(0, 1, 1, 1, 32, 36); push(1, 0, 1, 1, 32, 36); push(2, 1, 1, 1, 32, 33);
      run(5, 5, 5'd31, 32'd1, 0, 5'd0, 32'd0, 0, 0);
      wait_done();

      // write lands in DRAIN cycle 2; the no-drain instance is already DONE
      push(0, 1, 0, 1, 3, 7); push(1, 1, 0, 1, 3, 7); push(2, 0, 0, 0, 3, 4);
      run(5, 5, 5'd31, 32'd1, 0, 5'd0, 32'd0, 3, 0);
      wait_done();
      chk("done_hold_res_c", res[2], 0);
      chk("done_hold_fail_c", fail[2], 1);

      // only x30 and x0 written, stray start at cycle 3
      push(0, 0, 0, 0, 8, 12); push(1, 0, 0, 0, 8, 12); push(2, 0, 0, 0, 8, 9);
      run(8, 2, 5'd30, 32'd1, 4, 5'd0, 32'd1, 8, 3);
      wait_done();

      // reset during DRAIN cycle 2; the no-drain instance finishes before the reset
      push(2, 1, 0, 1, 2, 3);
      run(2, 1, 5'd31, 32'd1, 0, 5'd0, 32'd0, 2, 0);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("midrst_busy[%0d]", i), busy[i], 0);
         chk($sformatf("midrst_done[%0d]", i), done[i], 0);
         chk($sformatf("midrst_pass[%0d]", i), pass[i], 0);
         chk($sformatf("midrst_fail[%0d]", i), fail[i], 0);
         chk($sformatf("midrst_tmo[%0d]", i), tmo[i], 0);
         chk($sformatf("midrst_res[%0d]", i), res[i], 0);
         chk($sformatf("midrst_cyc[%0d]", i), cyo[i], 0);
      end
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle_busy", busy[0], 0);

      push(0, 1, 0, 1, 2, 6); push(1, 1, 0, 1, 2, 6); push(2, 1, 0, 1, 2, 3);
      run(2, 1, 5'd31, 32'd1, 0, 5'd0, 32'd0, 2, 0);
      wait_done();
      repeat (2) @(negedge clk);

      for (int i = 0; i < 3; i++)
         chk($sformatf("queue_empty[%0d]", i), sbq[i].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
